// File: rtl/float_div_pkg.sv
// float_div_pkg: shared operand classes, flag indices and delay-line tag for the float_div special-case merge
package float_div_pkg;
  typedef enum logic [2:0] {FD_ZERO, FD_FIN, FD_INF, FD_QNAN, FD_SNAN} fd_class_t;
  localparam int FD_NV = 3;
  localparam int FD_DZ = 2;
  localparam int FD_OF = 1;
  localparam int FD_UF = 0;
  localparam logic [31:0] QNAN_DEFAULT = 32'h7FC00000;
  typedef struct packed {
    logic        vld;
    logic        use_mul;
    logic [31:0] special_x;
    logic        nv;
    logic        dz;
  } fd_tag_t;
endpackage

// File: rtl/float_div_classify_e8m23.sv
// float_div_classify_e8m23: maps one E8/M23 operand to its class, subnormals flushed to zero
module float_div_classify_e8m23
  import float_div_pkg::*;
(
  input  logic [7:0]  exp,
  input  logic [22:0] man,
  output fd_class_t   cls
);
  assign cls = exp == 8'h00 ? FD_ZERO :
               exp != 8'hFF ? FD_FIN  :
               man == '0    ? FD_INF  :
               man[22]      ? FD_QNAN : FD_SNAN;
endmodule

// File: rtl/float_div_special_merge_pipe.sv
// float_div_special_merge_pipe: carries the special-case decision alongside the multiplier and merges it into the final quotient and flags; FLOAT_DIV_STICKY_FLAGS_EN enables the sticky flag register
module float_div_special_merge_pipe
  import float_div_pkg::*;
#(
  parameter int          MUL_LAT = 3,
  parameter logic [31:0] QNAN    = QNAN_DEFAULT
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        astall,
  input  logic        in_vld,
  input  logic        a_sign,
  input  logic [7:0]  a_exp,
  input  logic [22:0] a_man,
  input  logic        b_sign,
  input  logic [7:0]  b_exp,
  input  logic [22:0] b_man,
  input  logic [31:0] mul_x,
  input  logic        flag_clr,
  output logic        out_vld,
  output logic [31:0] x,
  output logic [3:0]  flags,
  output logic [3:0]  sticky_flags
);
  fd_class_t ca, cb;
  fd_tag_t   tag, tail;
  fd_tag_t   dl [MUL_LAT];
  logic      s, any_nan, any_snan, inv, a_inf, b_zero, a_zero, b_inf;
  logic [3:0] flags_next;
  float_div_classify_e8m23 u_cls_a (.exp(a_exp), .man(a_man), .cls(ca));
  float_div_classify_e8m23 u_cls_b (.exp(b_exp), .man(b_man), .cls(cb));
  assign s        = a_sign ^ b_sign;
  assign any_nan  = ca == FD_QNAN || ca == FD_SNAN || cb == FD_QNAN || cb == FD_SNAN;
  assign any_snan = ca == FD_SNAN || cb == FD_SNAN;
  assign a_inf    = ca == FD_INF;
  assign b_inf    = cb == FD_INF;
  assign a_zero   = ca == FD_ZERO;
  assign b_zero   = cb == FD_ZERO;
  assign inv      = (a_inf && b_inf) || (a_zero && b_zero);
  // Issue-time special-case decision; classes are exclusive so NaN and inf/inf or 0/0 never overlap
  always_comb begin
    tag.vld       = in_vld;
    tag.use_mul   = !(any_nan || inv || a_inf || b_zero || a_zero || b_inf);
    tag.special_x = (any_nan || inv) ? QNAN :
                    (a_inf || b_zero) ? {s, 8'hFF, 23'h0} : {s, 31'h0};
    tag.nv        = any_snan || inv;
    tag.dz        = !any_nan && !inv && !a_inf && b_zero;
  end
  assign tail = dl[MUL_LAT-1];
  // Result flags for the entry meeting mul_x this cycle
  always_comb begin
    flags_next        = '0;
    flags_next[FD_NV] = tail.nv;
    flags_next[FD_DZ] = tail.dz;
    flags_next[FD_OF] = tail.use_mul && mul_x[30:23] == 8'hFF;
    flags_next[FD_UF] = tail.use_mul && mul_x[30:23] == 8'h00;
  end
  // Stall-aware delay line aligned to the multiplier latency
  always_ff @(posedge aclk) begin
    if (areset)
      for (int i = 0; i < MUL_LAT; i++) dl[i] <= '0;
    else if (!astall) begin
      dl[0] <= tag;
      for (int i = 1; i < MUL_LAT; i++) dl[i] <= dl[i-1];
    end
  end
  // Output register; quotient and flags only move when a valid entry arrives
  always_ff @(posedge aclk) begin
    if (areset) begin
      out_vld <= 1'b0;
      x       <= '0;
      flags   <= '0;
    end else if (!astall) begin
      out_vld <= tail.vld;
      if (tail.vld) begin
        x     <= tail.use_mul ? mul_x : tail.special_x;
        flags <= flags_next;
      end
    end
  end
`ifdef FLOAT_DIV_STICKY_FLAGS_EN
  // Sticky accumulation; a new flagged result survives a same-cycle clear
  always_ff @(posedge aclk) begin
    if (areset)
      sticky_flags <= '0;
    else if (!astall)
      sticky_flags <= (flag_clr ? 4'b0 : sticky_flags) | (tail.vld ? flags_next : 4'b0);
  end
`else
  logic unused_flag_clr;
  assign unused_flag_clr = flag_clr;
  assign sticky_flags    = '0;
`endif
endmodule

// File: tb/tb_float_div_special_merge_pipe.sv
// tb_float_div_special_merge_pipe: directed vectors with hand-computed quotients, flags, latency, stall and sticky behaviour
module tb_float_div_special_merge_pipe;
  localparam int MUL_LAT = 3;
`ifdef FLOAT_DIV_STICKY_FLAGS_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif
  logic        clk = 0, rst = 1, astall = 0, in_vld = 0, flag_clr = 0;
  logic        a_sign = 0, b_sign = 0;
  logic [7:0]  a_exp = 0, b_exp = 0;
  logic [22:0] a_man = 0, b_man = 0;
  logic [31:0] mul_in = 0, mul_x, x;
  logic [31:0] mp [MUL_LAT];
  logic        out_vld;
  logic [3:0]  flags, sticky_flags;
  int          total = 0, passed = 0;
  float_div_special_merge_pipe #(.MUL_LAT(MUL_LAT)) dut (
    .aclk(clk), .areset(rst), .astall(astall), .in_vld(in_vld),
    .a_sign(a_sign), .a_exp(a_exp), .a_man(a_man),
    .b_sign(b_sign), .b_exp(b_exp), .b_man(b_man),
    .mul_x(mul_x), .flag_clr(flag_clr), .out_vld(out_vld), .x(x),
    .flags(flags), .sticky_flags(sticky_flags)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!astall) begin
      mp[0] <= mul_in;
      for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
    end
  end
  assign mul_x = mp[MUL_LAT-1];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else passed++;
  endtask
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] m);
    {a_sign, a_exp, a_man} = a;
    {b_sign, b_exp, b_man} = b;
    mul_in = m;
    in_vld = 1;
    @(negedge clk);
    in_vld = 0;
  endtask
  task automatic expect_out(input string tag, input logic [31:0] ex, input logic [3:0] ef);
    int n = 0;
    while (!out_vld && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, MUL_LAT);
    check({tag, "_x"}, x, ex);
    check({tag, "_flags"}, {28'h0, flags}, {28'h0, ef});
  endtask
  initial begin
    logic seen;
    repeat (2) @(negedge clk);
    check("rst_vld", {31'h0, out_vld}, 0);
    check("rst_x", x, 0);
    check("rst_flags", {28'h0, flags}, 0);
    check("rst_sticky", {28'h0, sticky_flags}, 0);
    rst = 0;
    op(32'h40C00000, 32'h40000000, 32'h40400000);
    expect_out("norm", 32'h40400000, 4'b0000);
    @(negedge clk);
    check("norm_single", {31'h0, out_vld}, 0);
    op(32'h3F800000, 32'h80000000, 32'h12345678);
    expect_out("dz", 32'hFF800000, 4'b0100);
    check("dz_sticky", {28'h0, sticky_flags}, STICKY ? 4'b0100 : 4'b0000);
    op(32'h00000000, 32'h00000000, 32'h12345678);
    expect_out("zz", 32'h7FC00000, 4'b1000);
    check("zz_sticky", {28'h0, sticky_flags}, STICKY ? 4'b1100 : 4'b0000);
    op(32'h7F800001, 32'h3F800000, 32'h12345678);
    expect_out("snan", 32'h7FC00000, 4'b1000);
    op(32'h3F800000, 32'h7FC00000, 32'h12345678);
    expect_out("qnan", 32'h7FC00000, 4'b0000);
    op(32'h7F800000, 32'hFF800000, 32'h12345678);
    expect_out("infinf", 32'h7FC00000, 4'b1000);
    op(32'h3F800000, 32'h3F800000, 32'h7F800000);
    expect_out("of", 32'h7F800000, 4'b0010);
    op(32'h40000000, 32'h3F800000, 32'h00000000);
    expect_out("uf", 32'h00000000, 4'b0001);
    op(32'hFF800000, 32'h3F800000, 32'h12345678);
    expect_out("ainf", 32'hFF800000, 4'b0000);
    op(32'h00000000, 32'h7F800000, 32'h12345678);
    expect_out("zinf", 32'h00000000, 4'b0000);
    op(32'h3F800000, 32'hFF800000, 32'h12345678);
    expect_out("binf", 32'h80000000, 4'b0000);
    op(32'h00000001, 32'h00000000, 32'h12345678);
    expect_out("daz", 32'h7FC00000, 4'b1000);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      {a_sign, a_exp, a_man} = 32'h3F800000;
      {b_sign, b_exp, b_man} = 32'h3F800000;
      mul_in = 32'h3F800001 + k;
      in_vld = 1;
      @(negedge clk);
    end
    in_vld = 0;
    for (int c = 3; c < 10; c++) begin
      astall = (c == 3 || c == 4);
      @(negedge clk);
      check("stall_vld", {31'h0, out_vld}, (c >= 5 && c <= 7) ? 1 : 0);
      if (c >= 5 && c <= 7) check("stall_x", x, 32'h3F800001 + c - 5);
    end
    astall = 0;
    op(32'h3F800000, 32'h3F800000, 32'h3F800000);
    rst = 1;
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= out_vld;
    end
    check("flush", {31'h0, seen}, 0);
    check("flush_sticky", {28'h0, sticky_flags}, 0);
    op(32'h3F800000, 32'h00000000, 32'h12345678);
    expect_out("sdz", 32'h7F800000, 4'b0100);
    check("sdz_sticky", {28'h0, sticky_flags}, STICKY ? 4'b0100 : 4'b0000);
    op(32'h00000000, 32'h00000000, 32'h12345678);
    repeat (MUL_LAT - 1) @(negedge clk);
    flag_clr = 1;
    @(negedge clk);
    flag_clr = 0;
    check("clr_vld", {31'h0, out_vld}, 1);
    check("clr_flags", {28'h0, flags}, 4'b1000);
    check("clr_sticky", {28'h0, sticky_flags}, STICKY ? 4'b1000 : 4'b0000);
    flag_clr = 1;
    @(negedge clk);
    flag_clr = 0;
    check("clr_only", {28'h0, sticky_flags}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
